// File: rtl/mprj_prefetch_ctrl.sv
// Wishbone-to-BRAM sequential prefetch controller for the user project RAM window.
// Optional PREFETCH_STATS_EN adds saturating hit/miss counters on hit_cnt_o/miss_cnt_o.
module mprj_prefetch_ctrl #(
  parameter int         ADDR_W     = 12,
  parameter int         FIFO_DEPTH = 8,
  parameter int         BRAM_LAT   = 10,
  parameter logic [7:0] BASE       = 8'h38
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              bram_en_o,
  output logic [3:0]        bram_we_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic [31:0]       bram_wdata_o,
  input  logic [31:0]       bram_rdata_i
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IF_W  = $clog2(BRAM_LAT + 2);
  localparam int AX_W  = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, MISS_WAIT, WR} state_t;

  state_t              state_reg, state_next;
  logic                ack_reg;
  logic [31:0]         dat_reg;
  logic                bram_en_reg;
  logic [3:0]          bram_we_reg;
  logic [ADDR_W-1:0]   bram_addr_reg;
  logic [31:0]         bram_wdata_reg;
  logic                rd_valid_reg;
  logic                rd_epoch_reg;
  logic                epoch_reg;
  logic [BRAM_LAT-1:0] sr_valid_reg;
  logic [BRAM_LAT-1:0] sr_epoch_reg;
  logic [BRAM_LAT-1:0] sr_live;
  // Extra top bit lets pf_next/head_addr step past the last word without wrapping to 0.
  logic [AX_W-1:0]     head_addr_reg;
  logic [AX_W-1:0]     pf_next_reg;
  logic [31:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [IF_W-1:0]     inflight;

  logic              req, accept, is_hit, is_miss, is_wr, flush;
  logic              ret_valid, demand_ret, push, pop, pf_issue, room;
  logic [ADDR_W-1:0] req_addr;
  logic [AX_W-1:0]   req_next;
  logic              unused_adr;

  assign unused_adr = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};

  assign req      = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:24] == BASE);
  assign req_addr = wbs_adr_i[ADDR_W+1:2];
  assign req_next = {1'b0, req_addr} + AX_W'(1);
  assign accept   = req & (state_reg == IDLE) & ~ack_reg;
  assign is_hit   = accept & ~wbs_we_i & (count_reg != '0) &
                    (head_addr_reg == {1'b0, req_addr});
  assign is_miss  = accept & ~wbs_we_i & ~is_hit;
  assign is_wr    = accept & wbs_we_i;
  assign flush    = is_miss | is_wr;

  generate
    for (genvar gi = 0; gi < BRAM_LAT; gi++) begin : g_live
      assign sr_live[gi] = sr_valid_reg[gi] & (sr_epoch_reg[gi] == epoch_reg);
    end
  endgenerate

  always_comb begin
    inflight = IF_W'(rd_valid_reg & (rd_epoch_reg == epoch_reg));
    for (int i = 0; i < BRAM_LAT; i++) begin
      if (sr_live[i]) inflight = inflight + IF_W'(1);
    end
  end

  // The demand read is the first issue after a flush, so the first live return in
  // MISS_WAIT is always the word the CPU is waiting for.
  assign ret_valid  = sr_live[BRAM_LAT-1];
  assign demand_ret = ret_valid & (state_reg == MISS_WAIT);
  assign push       = ret_valid & ~demand_ret & ~flush;
  assign pop        = is_hit;
  assign room       = (32'(count_reg) + 32'(inflight)) < 32'(FIFO_DEPTH);
  assign pf_issue   = ~flush & ~pf_next_reg[ADDR_W] & room;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (is_miss)    state_next = MISS_WAIT;
        else if (is_wr) state_next = WR;
      end
      MISS_WAIT: if (demand_ret) state_next = IDLE;
      WR:        state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_reg        <= 1'b0;
      dat_reg        <= '0;
      bram_en_reg    <= 1'b0;
      bram_we_reg    <= '0;
      bram_addr_reg  <= '0;
      bram_wdata_reg <= '0;
      rd_valid_reg   <= 1'b0;
      rd_epoch_reg   <= 1'b0;
      epoch_reg      <= 1'b0;
      // Prefetch stays parked past the top word until the first miss or write.
      head_addr_reg  <= {1'b1, {ADDR_W{1'b0}}};
      pf_next_reg    <= {1'b1, {ADDR_W{1'b0}}};
    end else begin
      ack_reg      <= 1'b0;
      bram_en_reg  <= 1'b0;
      bram_we_reg  <= '0;
      rd_valid_reg <= 1'b0;

      if (is_hit) begin
        ack_reg       <= 1'b1;
        dat_reg       <= fifo_mem[rd_ptr_reg];
        head_addr_reg <= head_addr_reg + AX_W'(1);
      end
      if (demand_ret) begin
        ack_reg <= 1'b1;
        dat_reg <= bram_rdata_i;
      end
      if (state_reg == WR) ack_reg <= 1'b1;

      if (is_miss) begin
        bram_en_reg   <= 1'b1;
        bram_addr_reg <= req_addr;
        rd_valid_reg  <= 1'b1;
        rd_epoch_reg  <= ~epoch_reg;
        epoch_reg     <= ~epoch_reg;
        head_addr_reg <= req_next;
        pf_next_reg   <= req_next;
      end else if (is_wr) begin
        bram_en_reg    <= 1'b1;
        bram_we_reg    <= wbs_sel_i;
        bram_addr_reg  <= req_addr;
        bram_wdata_reg <= wbs_dat_i;
        epoch_reg      <= ~epoch_reg;
        head_addr_reg  <= req_next;
        pf_next_reg    <= req_next;
      end else if (pf_issue) begin
        bram_en_reg   <= 1'b1;
        bram_addr_reg <= pf_next_reg[ADDR_W-1:0];
        rd_valid_reg  <= 1'b1;
        rd_epoch_reg  <= epoch_reg;
        pf_next_reg   <= pf_next_reg + AX_W'(1);
      end
    end
  end

  // Flush also kills every tracked read so a double epoch toggle cannot revive stale data.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || flush) begin
      sr_valid_reg <= '0;
      sr_epoch_reg <= '0;
    end else begin
      for (int i = BRAM_LAT - 1; i > 0; i--) begin
        sr_valid_reg[i] <= sr_valid_reg[i-1];
        sr_epoch_reg[i] <= sr_epoch_reg[i-1];
      end
      sr_valid_reg[0] <= rd_valid_reg;
      sr_epoch_reg[0] <= rd_epoch_reg;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) fifo_mem[wr_ptr_reg] <= bram_rdata_i;
  end

`ifdef PREFETCH_STATS_EN
  logic [31:0] hit_cnt_reg, miss_cnt_reg;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      if (is_hit && hit_cnt_reg != 32'hFFFF_FFFF)       hit_cnt_reg  <= hit_cnt_reg + 32'd1;
      if (demand_ret && miss_cnt_reg != 32'hFFFF_FFFF)  miss_cnt_reg <= miss_cnt_reg + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_reg;
  assign miss_cnt_o = miss_cnt_reg;
`endif

  assign wbs_ack_o    = ack_reg & wbs_stb_i;
  assign wbs_dat_o    = dat_reg;
  assign bram_en_o    = bram_en_reg;
  assign bram_we_o    = bram_we_reg;
  assign bram_addr_o  = bram_addr_reg;
  assign bram_wdata_o = bram_wdata_reg;

endmodule

// File: tb/tb_mprj_prefetch_ctrl.sv
// Directed bench for mprj_prefetch_ctrl with a latency-accurate byte-writable BRAM model.
module tb_mprj_prefetch_ctrl;

  localparam int LAT = 10;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        bram_en_o;
  logic [3:0]  bram_we_o;
  logic [11:0] bram_addr_o;
  logic [31:0] bram_wdata_o;
  logic [31:0] bram_rdata_i;
`ifdef PREFETCH_STATS_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int ack_total   = 0;
  int ack_no_stb  = 0;
  int en_total    = 0;
  int wrap_total  = 0;
  logic mem_load  = 1'b1;

  always #5 wb_clk_i = ~wb_clk_i;

  mprj_prefetch_ctrl dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .wbs_stb_i    (wbs_stb_i),
    .wbs_cyc_i    (wbs_cyc_i),
    .wbs_we_i     (wbs_we_i),
    .wbs_sel_i    (wbs_sel_i),
    .wbs_adr_i    (wbs_adr_i),
    .wbs_dat_i    (wbs_dat_i),
    .wbs_ack_o    (wbs_ack_o),
    .wbs_dat_o    (wbs_dat_o),
    .bram_en_o    (bram_en_o),
    .bram_we_o    (bram_we_o),
    .bram_addr_o  (bram_addr_o),
    .bram_wdata_o (bram_wdata_o),
    .bram_rdata_i (bram_rdata_i)
`ifdef PREFETCH_STATS_EN
    ,
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
`endif
  );

  // BRAM model: word issued in cycle C appears on bram_rdata_i in cycle C+LAT.
  logic [31:0] mem  [0:4095];
  logic [31:0] pipe [0:LAT-1];

  always @(posedge wb_clk_i) begin
    if (mem_load) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'hA500_0000 + 32'(i);
    end else if (bram_en_o && bram_we_o != 4'b0000) begin
      for (int b = 0; b < 4; b++)
        if (bram_we_o[b]) mem[bram_addr_o][8*b +: 8] <= bram_wdata_o[8*b +: 8];
    end
    pipe[0] <= (bram_en_o && bram_we_o == 4'b0000) ? mem[bram_addr_o] : 32'h0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bram_rdata_i = pipe[LAT-1];

  always @(negedge wb_clk_i) begin
    if (wbs_ack_o) ack_total++;
    if (wbs_ack_o && !wbs_stb_i) ack_no_stb++;
    if (bram_en_o) en_total++;
    if (bram_en_o && bram_addr_o == 12'h000) wrap_total++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that ends the ack cycle.
  task automatic wb_xfer(input string tag, input logic we, input logic [31:0] adr,
                         input logic [31:0] wdat, input logic [3:0] sel,
                         input int exp_lat, input logic [31:0] exp_dat, input bit chk_dat);
    int          lat;
    bit          got;
    logic [31:0] rd;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = wdat; wbs_sel_i = sel;
    lat = 0; got = 1'b0; rd = '0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) begin
        got = 1'b1;
        rd  = wbs_dat_o;
      end else begin
        lat++;
      end
    end
    @(posedge wb_clk_i); #1;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    $display("txn %s we=%0d adr=%h lat=%0d dat=%h", tag, we, adr, lat, rd);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (chk_dat) chk({tag, "_dat"}, rd, exp_dat);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ack_snap, en_snap, wrap_snap;
    wb_rst_i = 1'b1; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = '0; wbs_dat_i = '0;

    // 1: reset then idle
    @(posedge wb_clk_i); #1; mem_load = 1'b0;
    repeat (4) @(posedge wb_clk_i);
    #1; wb_rst_i = 1'b0;
    idle_cycles(3);
    @(negedge wb_clk_i);
    chk("t1_ack",  32'(wbs_ack_o), 32'h0);
    chk("t1_en",   32'(bram_en_o), 32'h0);
    chk("t1_we",   32'(bram_we_o), 32'h0);
    chk("t1_dat",  wbs_dat_o,      32'h0);
    @(posedge wb_clk_i); #1;

    // 2: sequential reads, cold miss then prefetch hits
    wb_xfer("t2_rd0", 1'b0, 32'h3800_0000, 32'h0, 4'hF, 12, 32'hA500_0000, 1'b1);
    for (int i = 1; i < 8; i++)
      wb_xfer($sformatf("t2_rd%0d", i), 1'b0, 32'h3800_0000 + 32'(4 * i), 32'h0, 4'hF,
              1, 32'hA500_0000 + 32'(i), 1'b1);
`ifdef PREFETCH_STATS_EN
    chk("t2_hit_cnt",  hit_cnt_o,  32'd7);
    chk("t2_miss_cnt", miss_cnt_o, 32'd1);
`endif

    // 3: discontinuity flushes the prefetched run
    wb_xfer("t3_rd40", 1'b0, 32'h3800_0100, 32'h0, 4'hF, 12, 32'hA500_0040, 1'b1);
    wb_xfer("t3_rd41", 1'b0, 32'h3800_0104, 32'h0, 4'hF, 1,  32'hA500_0041, 1'b1);

    // 4: partial write then read-back
    wb_xfer("t4_wr1", 1'b1, 32'h3800_0004, 32'hDEAD_BEEF, 4'b0011, 2, 32'h0, 1'b0);
    wb_xfer("t4_rd1", 1'b0, 32'h3800_0004, 32'h0, 4'hF, 12, 32'hA500_BEEF, 1'b1);
    wb_xfer("t4_rd2", 1'b0, 32'h3800_0008, 32'h0, 4'hF, 1,  32'hA500_0002, 1'b1);

    // 5: top word, prefetch must stop instead of wrapping
    wb_xfer("t5_rdtop", 1'b0, 32'h3800_3FFC, 32'h0, 4'hF, 12, 32'hA500_0FFF, 1'b1);
    en_snap = en_total; wrap_snap = wrap_total;
    idle_cycles(20);
    chk("t5_en_after_top", 32'(en_total - en_snap),     32'd0);
    chk("t5_wrap",         32'(wrap_total - wrap_snap), 32'd0);

    // 6: reset in the middle of a miss
    ack_snap = ack_total;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3800_0200;
    repeat (5) @(posedge wb_clk_i);
    #1; wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    @(negedge wb_clk_i);
    chk("t6_en_after_rst",  32'(bram_en_o), 32'h0);
    chk("t6_dat_after_rst", wbs_dat_o,      32'h0);
    idle_cycles(20);
    chk("t6_no_ack", 32'(ack_total - ack_snap), 32'd0);
    wb_xfer("t6_reissue", 1'b0, 32'h3800_0200, 32'h0, 4'hF, 12, 32'hA500_0080, 1'b1);

    chk("ack_without_stb", 32'(ack_no_stb), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
